multiplier_1dsp_seq: RTL and testbench
======================================

Name: multiplier_1dsp_seq

Overview:
- Parametrised sequential signed multiplier (optional accumulate) time-shared on one 18x18 signed DSP multiplier.
- Operands are split into limbs. The partial products are issued one per cycle, shifted, and summed.
- Replaces the fixed 35x35 one-DSP multiplier. Adds ready/valid handshake, generic widths, configurable DSP latency, a full-width result and a MAC mode.

Parameters:
- A_W, 35, width of signed operand A (2..69).
- B_W, 35, width of signed operand B (2..69).
- ACC_W, A_W+B_W, result/accumulator width (>= A_W+B_W).
- DSP_LAT, 2, register stages of the internal 18x18 multiplier (>= 1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  operand strobe.
- i_a  in  A_W  signed operand A.
- i_b  in  B_W  signed operand B.
- i_acc  in  1  1: add product to current o_p; 0: replace. Sampled with operands.
- o_ready  out  1  block can accept operands this cycle.
- o_p  out  ACC_W  signed result, held until next completion.
- o_valid  out  1  one-cycle pulse, o_p updated.

Behaviour:
- Reset (async assert, sync deassert internally): o_ready=1, o_valid=0, o_p=0, FSM=IDLE, counters/pipeline cleared. Reset mid-operation aborts it: no o_valid, o_p=0.
- Limbing:
  - NA = 1 if A_W<=18, else 1+ceil((A_W-18)/17). NB likewise.
  - Lower limbs are 17 bits, zero-extended to 18 (unsigned).
  - Top limb is the remaining bits, sign-extended to 18.
  - Defaults: NA=NB=2, N=NA*NB=4 products.
- Partial product (i,j) is sign-extended to ACC_W and shifted left 17*(i+j). Any issue order is allowed.
- Accept: i_valid & o_ready at a rising edge latches i_a, i_b and i_acc. The FSM goes to ISSUE and o_ready drops.
- FSM:
  - IDLE: o_ready=1.
  - ISSUE: N cycles, one limb pair per cycle to the DSP.
  - DRAIN: DSP_LAT cycles while the last products emerge.
  - DONE: 1 cycle. o_valid=1, o_p updated this cycle. o_ready=1. Goes to ISSUE on accept, else IDLE.
- Latency: o_valid is high in cycle L = N + DSP_LAT + 1 after the accept edge. Default L=7.
- Throughput: one operation per L cycles; back-to-back accept is allowed in the DONE cycle.
- i_valid while o_ready=0 is ignored. Nothing is queued and i_a/i_b changes have no effect.
- Arithmetic:
  - i_acc=0: o_p = A*B, exact for ACC_W >= A_W+B_W. This includes (-2^(A_W-1))^2.
  - i_acc=1: o_p = o_p_prev + A*B, wrapping modulo 2^ACC_W with no saturation or flag.
  - Accumulation uses an internal register. o_p changes only in the DONE cycle.
- The internal accumulator starts each operation from 0 or from o_p per the latched i_acc.

Test Plan:
- Defaults, A=3, B=5, i_acc=0 -> o_valid exactly 7 cycles after accept, o_p=15; o_ready low for cycles 1..6.
- A=-2^34, B=-2^34 -> o_p=2^68 (70-bit positive). A=-1, B=2^34-1 -> o_p=-(2^34-1).
- MAC:
  - A=3, B=5, i_acc=0 -> 15.
  - Then A=2, B=-4, i_acc=1 -> 7.
  - Then ACC_W=70 with o_p near 2^69-1 plus a positive product -> wraps negative.
- Handshake:
  - Pulse i_valid with A=7, B=9 at cycles 2..5 after an accept -> ignored, result of the first pair only.
  - Accept in the DONE cycle -> next o_valid at L cycles later.
- Drop i_rst_n at cycle 4 of an operation -> o_p=0, o_valid never pulses, o_ready=1 after release.
- A_W=18, B_W=52, DSP_LAT=3: A=-131072, B=2^51-1 -> L=7, o_p=-131072*(2^51-1). Randomised 1000-pair check vs reference model.

Source files
------------

// File: rtl/multiplier_1dsp_seq.sv
// Sequential signed multiplier / MAC built around one pipelined 18x18 signed DSP
// multiplier: operands are split into 17-bit limbs and partial products are summed.
module multiplier_1dsp_seq #(
  parameter int A_W     = 35,
  parameter int B_W     = 35,
  parameter int ACC_W   = A_W + B_W,
  parameter int DSP_LAT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [A_W-1:0]   i_a,
  input  logic [B_W-1:0]   i_b,
  input  logic             i_acc,
  output logic             o_ready,
  output logic [ACC_W-1:0] o_p,
  output logic             o_valid
);

  localparam int NA    = (A_W <= 18) ? 1 : 1 + (A_W - 18 + 16) / 17;
  localparam int NB    = (B_W <= 18) ? 1 : 1 + (B_W - 18 + 16) / 17;
  localparam int AX_W  = 17 * NA + 1;
  localparam int BX_W  = 17 * NB + 1;
  localparam int AIX_W = $clog2(AX_W);
  localparam int BIX_W = $clog2(BX_W);
  localparam int EXT_W = (ACC_W > 36) ? ACC_W : 36;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]              rst_sync;
  logic                    rst_int_n;
  logic [A_W-1:0]          a_q;
  logic [B_W-1:0]          b_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        p_q;
  logic [3:0]              ia;
  logic [3:0]              ib;
  logic                    accept;
  logic                    last_issue;
  logic signed [AX_W-1:0]  a_ext;
  logic signed [BX_W-1:0]  b_ext;
  logic [AIX_W-1:0]        a_base;
  logic [BIX_W-1:0]        b_base;
  logic signed [17:0]      a_limb;
  logic signed [17:0]      b_limb;
  logic signed [35:0]      dsp_prod;
  logic signed [35:0]      prod_q [DSP_LAT];
  logic                    vld_q  [DSP_LAT];
  logic                    last_q [DSP_LAT];
  logic [3:0]              sh_q   [DSP_LAT];
  logic                    out_valid;
  logic                    out_last;
  logic signed [EXT_W-1:0] pp_wide;
  logic signed [EXT_W-1:0] pp_shift;
  logic [ACC_W-1:0]        acc_sum;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n  = rst_sync[1];
  assign o_ready    = (state == IDLE) || (state == DONE);
  assign o_valid    = (state == DONE);
  assign o_p        = p_q;
  assign accept     = i_valid && o_ready;
  assign last_issue = (state == ISSUE) && (ia == 4'(NA - 1)) && (ib == 4'(NB - 1));

  assign a_ext  = AX_W'($signed(a_q));
  assign b_ext  = BX_W'($signed(b_q));
  assign a_base = AIX_W'(17 * ia);
  assign b_base = BIX_W'(17 * ib);

  // Lower limbs are unsigned 17-bit chunks; only the top limb carries the sign.
  always_comb begin
    a_limb = {1'b0, a_ext[a_base +: 17]};
    b_limb = {1'b0, b_ext[b_base +: 17]};
    if (ia == 4'(NA - 1)) a_limb = a_ext[a_base +: 18];
    if (ib == 4'(NB - 1)) b_limb = b_ext[b_base +: 18];
  end

  assign dsp_prod = 36'(a_limb) * 36'(b_limb);

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int k = 0; k < DSP_LAT; k++) begin
        prod_q[k] <= '0;
        vld_q[k]  <= 1'b0;
        last_q[k] <= 1'b0;
        sh_q[k]   <= '0;
      end
    end else begin
      prod_q[0] <= dsp_prod;
      vld_q[0]  <= (state == ISSUE);
      last_q[0] <= last_issue;
      sh_q[0]   <= ia + ib;
      for (int k = 1; k < DSP_LAT; k++) begin
        prod_q[k] <= prod_q[k-1];
        vld_q[k]  <= vld_q[k-1];
        last_q[k] <= last_q[k-1];
        sh_q[k]   <= sh_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[DSP_LAT-1];
  assign out_last  = last_q[DSP_LAT-1];
  assign pp_wide   = EXT_W'(prod_q[DSP_LAT-1]);
  assign pp_shift  = pp_wide <<< (17 * sh_q[DSP_LAT-1]);
  assign acc_sum   = acc_q + pp_shift[ACC_W-1:0];

  // Operand capture, limb counters and the running sum; o_p only moves on the final product.
  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      p_q   <= '0;
      ia    <= '0;
      ib    <= '0;
    end else begin
      if (accept) begin
        a_q   <= i_a;
        b_q   <= i_b;
        acc_q <= i_acc ? p_q : '0;
        ia    <= '0;
        ib    <= '0;
      end else begin
        if (state == ISSUE) begin
          if (ia == 4'(NA - 1)) begin
            ia <= '0;
            ib <= ib + 4'd1;
          end else begin
            ia <= ia + 4'd1;
          end
        end
        if (out_valid) begin
          acc_q <= acc_sum;
          if (out_last) p_q <= acc_sum;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (out_valid && out_last) state_nxt = DONE;
      DONE:    state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multiplier_1dsp_seq.sv
// Bench for multiplier_1dsp_seq: default 35x35 instance with directed vectors, MAC,
// handshake and reset cases, plus an 18x52 instance with randomised operands.
module tb_multiplier_1dsp_seq;

  logic i_clk;

  logic               rst_n, valid, acc, ready, ovalid;
  logic signed [34:0] a, b;
  logic signed [69:0] p;

  logic               rst2_n, valid2, acc2, ready2, ovalid2;
  logic signed [17:0] a2;
  logic signed [51:0] b2;
  logic signed [69:0] p2;

  int checks = 0;
  int errors = 0;

  logic signed [69:0] ref_p  = '0;
  logic signed [69:0] ref_p2 = '0;

  typedef struct {
    logic signed [34:0] a;
    logic signed [34:0] b;
    logic               acc;
    bit                 b2b;
    logic signed [69:0] exp;
  } vec_t;

  vec_t vecs [8];

  multiplier_1dsp_seq dut (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_valid(valid), .i_a(a), .i_b(b), .i_acc(acc),
    .o_ready(ready), .o_p(p), .o_valid(ovalid)
  );

  multiplier_1dsp_seq #(.A_W(18), .B_W(52), .ACC_W(70), .DSP_LAT(3)) dut2 (
    .i_clk(i_clk), .i_rst_n(rst2_n), .i_valid(valid2), .i_a(a2), .i_b(b2), .i_acc(acc2),
    .o_ready(ready2), .o_p(p2), .o_valid(ovalid2)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic signed [69:0] modelMac(input logic signed [69:0] prev,
                                                  input logic signed [69:0] x,
                                                  input logic signed [69:0] y,
                                                  input logic accf);
    return accf ? prev + x * y : x * y;
  endfunction

  task automatic checkOutput(input string name, input logic signed [69:0] got,
                             input logic signed [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called one tick after a rising edge of a cycle in which the block is ready.
  task automatic applyStimulus(input logic signed [34:0] ta, input logic signed [34:0] tb,
                               input logic tacc, input bit noise,
                               output logic signed [69:0] got, output int lat,
                               output int ready_bad);
    a = ta; b = tb; acc = tacc; valid = 1'b1;
    @(posedge i_clk); #1;
    valid = 1'b0;
    a = 35'({$urandom, $urandom});
    b = 35'({$urandom, $urandom});
    lat = 1;
    ready_bad = 0;
    while (!ovalid && lat < 40) begin
      if (ready) ready_bad++;
      if (noise && lat >= 2 && lat <= 5) begin
        valid = 1'b1; a = 35'sd7; b = 35'sd9;
      end else begin
        valid = 1'b0;
      end
      @(posedge i_clk); #1;
      lat++;
    end
    valid = 1'b0;
    got = p;
  endtask

  task automatic applyStimulusWide(input logic signed [17:0] ta, input logic signed [51:0] tb,
                                   input logic tacc,
                                   output logic signed [69:0] got, output int lat);
    a2 = ta; b2 = tb; acc2 = tacc; valid2 = 1'b1;
    @(posedge i_clk); #1;
    valid2 = 1'b0;
    a2 = 18'($urandom);
    lat = 1;
    while (!ovalid2 && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
    got = p2;
  endtask

  initial begin
    logic signed [69:0] got;
    int lat, ready_bad, pulses;
    logic signed [34:0] ra, rb;
    logic signed [17:0] wa;
    logic signed [51:0] wb;
    logic racc;

    vecs[0] = '{35'sd3, 35'sd5, 1'b0, 1'b0, 70'sd15};
    vecs[1] = '{35'sd2, -35'sd4, 1'b1, 1'b1, 70'sd7};
    vecs[2] = '{35'sh4_0000_0000, 35'sh4_0000_0000, 1'b0, 1'b0, 70'sd1 <<< 68};
    vecs[3] = '{-35'sd1, 35'sh3_FFFF_FFFF, 1'b0, 1'b1, -((70'sd1 <<< 34) - 70'sd1)};
    vecs[4] = '{35'sh4_0000_0000, 35'sh4_0000_0000, 1'b0, 1'b0, 70'sd1 <<< 68};
    vecs[5] = '{35'sh3_FFFF_FFFF, 35'sh3_FFFF_FFFF, 1'b1, 1'b1,
                (70'sd1 <<< 69) - (70'sd1 <<< 35) + 70'sd1};
    vecs[6] = '{35'sh3_FFFF_FFFF, 35'sh3_FFFF_FFFF, 1'b1, 1'b0,
                -(70'sd1 <<< 68) - (70'sd1 <<< 36) + 70'sd2};
    vecs[7] = '{35'sd12345, -35'sd6789, 1'b0, 1'b1, -70'sd83810205};

    rst_n = 1'b0; rst2_n = 1'b0;
    valid = 1'b0; a = '0; b = '0; acc = 1'b0;
    valid2 = 1'b0; a2 = '0; b2 = '0; acc2 = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_ready", 70'(ready), 70'd1);
    checkOutput("reset_valid", 70'(ovalid), 70'd0);
    checkOutput("reset_p", p, 70'sd0);
    @(negedge i_clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].b2b) begin
        @(posedge i_clk); #1;
      end
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].acc, 1'b0, got, lat, ready_bad);
      checkOutput($sformatf("vec%0d_p", i), got, vecs[i].exp);
      checkOutput($sformatf("vec%0d_latency", i), 70'(lat), 70'sd7);
      checkOutput($sformatf("vec%0d_ready_low", i), 70'(ready_bad), 70'sd0);
    end
    ref_p = vecs[7].exp;

    @(posedge i_clk); #1;
    checkOutput("valid_is_pulse", 70'(ovalid), 70'd0);
    checkOutput("idle_ready", 70'(ready), 70'd1);

    applyStimulus(35'sd100, -35'sd3, 1'b0, 1'b1, got, lat, ready_bad);
    checkOutput("ignore_p", got, -70'sd300);
    checkOutput("ignore_latency", 70'(lat), 70'sd7);
    pulses = 0;
    repeat (10) begin
      @(posedge i_clk); #1;
      if (ovalid) pulses++;
    end
    checkOutput("ignore_no_extra_op", 70'(pulses), 70'sd0);

    a = 35'sd11; b = 35'sd13; acc = 1'b0; valid = 1'b1;
    @(posedge i_clk); #1;
    valid = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_p", p, 70'sd0);
    checkOutput("midreset_valid", 70'(ovalid), 70'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge i_clk); #1;
      if (ovalid) pulses++;
    end
    checkOutput("midreset_no_valid", 70'(pulses), 70'sd0);
    checkOutput("midreset_ready", 70'(ready), 70'd1);
    ref_p = '0;
    applyStimulus(35'sd4, 35'sd5, 1'b1, 1'b0, got, lat, ready_bad);
    ref_p = modelMac(ref_p, 70'sd4, 70'sd5, 1'b1);
    checkOutput("after_reset_mac", got, ref_p);

    for (int i = 0; i < 200; i++) begin
      ra = 35'({$urandom, $urandom});
      rb = 35'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) ra = 35'sh4_0000_0000;
      if ($urandom_range(0, 7) == 0) rb = 35'sh3_FFFF_FFFF;
      racc = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge i_clk); #1;
      end
      applyStimulus(ra, rb, racc, 1'b0, got, lat, ready_bad);
      ref_p = modelMac(ref_p, ra, rb, racc);
      checkOutput($sformatf("rand%0d_p a=%0d b=%0d acc=%0d", i, ra, rb, racc), got, ref_p);
      checkOutput($sformatf("rand%0d_latency", i), 70'(lat), 70'sd7);
    end

    @(posedge i_clk); #1;
    applyStimulusWide(-18'sd131072, 52'sh7_FFFF_FFFF_FFFF, 1'b0, got, lat);
    checkOutput("wide_corner_p", got, -70'sd131072 * ((70'sd1 <<< 51) - 70'sd1));
    checkOutput("wide_corner_latency", 70'(lat), 70'sd7);
    ref_p2 = -70'sd131072 * ((70'sd1 <<< 51) - 70'sd1);

    for (int i = 0; i < 1000; i++) begin
      wa = 18'($urandom);
      wb = 52'({$urandom, $urandom});
      if ($urandom_range(0, 9) == 0) wa = -18'sd131072;
      if ($urandom_range(0, 9) == 0) wb = {1'b1, 51'b0};
      racc = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge i_clk); #1;
      end
      applyStimulusWide(wa, wb, racc, got, lat);
      ref_p2 = modelMac(ref_p2, wa, wb, racc);
      checkOutput($sformatf("wide%0d_p a=%0d b=%0d acc=%0d", i, wa, wb, racc), got, ref_p2);
      checkOutput($sformatf("wide%0d_latency", i), 70'(lat), 70'sd7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
